uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Sits upstream of the cache/memory on the rx_data path. It consumes the byte
//  stream from the UART receiver and assembles little-endian 32-bit words. It
//  writes them to instruction/data memory at consecutive word addresses.
//  It holds the MIPS core in reset until the programme image is fully loaded.
// PARAMETERS
//  AW       8          word-address width (matches the 8-bit memory word index)
//  DEPTH    256        max words accepted; must satisfy DEPTH <= 2**AW
//  TIMEOUT  1000000    idle clocks allowed between bytes once loading starts
// PORTS
//  clk        in   1   system clock; all logic is rising-edge
//  reset      in   1   synchronous, active-high reset
//  rx_data    in   8   received byte; sampled only when rx_valid=1
//  rx_valid   in   1   one-cycle strobe per received byte
//  mem_we     out  1   one-cycle memory write pulse
//  mem_addr   out  AW  word address of the current write
//  mem_wdata  out  32  assembled word; first byte received is bits[7:0]
//  cpu_reset  out  1   reset to the core; high until the load completes
//  done       out  1   load completed successfully; sticky until reset
//  err        out  2   00 none, 01 count>DEPTH, 10 inter-byte timeout; sticky
//  words_left out  16  remaining words to load (debug/check output)
// BEHAVIOUR
//  Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0,
//   err=00, words_left=0, state=CNT_LO, byte index=0, timeout counter=0.
//  Protocol: 2-byte word count N (LSB first), then 4*N data bytes.
//  States:
//   CNT_LO: byte -> N[7:0]; go to CNT_HI. No timeout runs in this state.
//   CNT_HI: byte -> N[15:8]. Then evaluate the full count:
//    N==0 -> DONE; N>DEPTH -> ERROR with err=01; otherwise -> DATA with
//    words_left=N.
//   DATA: byte k (k=0..3) goes to wdata[8k+7:8k]. On the byte with k=3, the
//    cycle after its rx_valid: mem_we=1 for exactly one cycle, mem_addr =
//    current word index, and mem_wdata holds the full word.
//    words_left decrements in that same cycle.
//    The word index then increments and k returns to 0.
//    When words_left reaches 0 -> DONE in the same cycle as the last mem_we.
//    Consequence: cpu_reset falls one cycle after the final write pulse.
//   DONE: cpu_reset=0, done=1. All further rx_valid bytes are ignored.
//   ERROR: cpu_reset=1, mem_we=0. Bytes are ignored; only reset exits.
//  Timeout: applies in CNT_HI and DATA only.
//   The counter clears on every rx_valid and otherwise increments.
//   When it reaches TIMEOUT-1 with no byte -> ERROR, err=10.
//   A partial word is discarded and never written.
//  Back-to-back bytes: rx_valid may be high on consecutive cycles, with no loss.
//   A write pulse may coincide with the next word's byte 0; both are handled.
//  mem_addr and mem_wdata hold their last values when mem_we=0.
//  Address never wraps: N<=DEPTH<=2**AW guarantees this.
//  Reset mid-load: all state returns to reset values and the next byte is
//   treated as CNT_LO. Memory already written is left as is.
//  Counters: timeout width = $clog2(TIMEOUT+1); word index width = AW.
// TESTING
//  1 Bytes 01 00 78 56 34 12 -> one mem_we, addr=0, wdata=32'h12345678.
//    The next cycle gives done=1 and cpu_reset=0.
//  2 Count 00 00 -> done=1 and cpu_reset=0 after byte 2, with no mem_we pulses.
//  3 Count 2C 01 (300) with DEPTH=256 -> err=01, cpu_reset stays 1.
//    Later data bytes cause no mem_we.
//  4 Count=3 with all 12 bytes on consecutive cycles -> writes at addr 0,1,2.
//    Data is correct, words_left reaches 0, done=1.
//  5 TIMEOUT=16: count=1 then 2 bytes, then 20 idle cycles -> err=10.
//    No mem_we; cpu_reset stays 1.
//  6 Assert reset after 5 data bytes of a 2-word load, then a full 1-word
//    stream -> a single write at addr 0 and done=1.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles a length-prefixed little-endian byte stream into
// 32-bit memory writes and holds the core in reset until the image is loaded.
//
// state  | meaning
// CNT_LO | waiting for word count bits [7:0]
// CNT_HI | waiting for word count bits [15:8], then validate count
// DATA   | assembling 4-byte words and writing them out
// DONE   | load complete, core released, bytes ignored
// ERROR  | bad count or inter-byte timeout, core held, bytes ignored
module uart_boot_loader #(
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic [1:0]    err,
    output logic [15:0]   words_left
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_CNT_LO = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]    state;
    logic [7:0]    cnt_lo;
    logic [1:0]    byte_idx;
    logic [23:0]   wbuf;
    logic [AW-1:0] word_idx;
    logic [TW-1:0] tmr;
    logic [15:0]   cnt_full;
    logic          timed;

    assign cnt_full = {rx_data, cnt_lo};
    assign timed    = (state == S_CNT_HI) || (state == S_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CNT_LO;
            cnt_lo     <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            word_idx   <= '0;
            tmr        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 2'b00;
            words_left <= '0;
        end else begin
            mem_we <= 1'b0;

            if (rx_valid || !timed)
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);

            case (state)
                S_CNT_LO: begin
                    if (rx_valid) begin
                        cnt_lo <= rx_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (rx_valid) begin
                        if (cnt_full == 16'd0) begin
                            state <= S_DONE;
                        end else if ({1'b0, cnt_full} > 17'(DEPTH)) begin
                            state <= S_ERROR;
                            err   <= 2'b01;
                        end else begin
                            state      <= S_DATA;
                            words_left <= cnt_full;
                        end
                    end else if (tmr == TMR_LAST) begin
                        state <= S_ERROR;
                        err   <= 2'b10;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte goes straight to the output word, not wbuf
                        if (byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= word_idx;
                            mem_wdata  <= {rx_data, wbuf};
                            words_left <= words_left - 16'd1;
                            word_idx   <= word_idx + AW'(1);
                            if (words_left == 16'd1)
                                state <= S_DONE;
                        end else begin
                            wbuf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end
                    end else if (tmr == TMR_LAST) begin
                        state <= S_ERROR;
                        err   <= 2'b10;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
                end
                default: begin
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes are queued by the
// stimulus and popped by a monitor on each mem_we; status is checked directly.
module tb_uart_boot_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic [1:0]    err;
    logic [15:0]   words_left;

    int checks = 0;
    int failures = 0;
    logic [39:0] sb[$];

    uart_boot_loader #(.AW(AW), .DEPTH(256), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err), .words_left(words_left)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            logic [39:0] e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                             mem_addr, mem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves at the next posedge+1 with rx_valid low
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w);
        sb.push_back({addr, w});
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic sb_empty(input string name);
        tick(3);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        tick(2);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words_left", words_left, 0);
        reset = 1'b0;
        tick(1);

        // Single word
        send_byte(8'h01); send_byte(8'h00);
        chk("t1_words_left", words_left, 1);
        send_word(8'd0, 32'h12345678);
        chk("t1_done_early", done, 0);
        chk("t1_cpu_reset_early", cpu_reset, 1);
        tick(1);
        chk("t1_done", done, 1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_words_left_end", words_left, 0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        sb_empty("t1_sb");
        chk("t1_done_sticky", done, 1);

        // Zero-length image
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        tick(1);
        chk("t2_done", done, 1);
        chk("t2_cpu_reset", cpu_reset, 0);
        chk("t2_err", err, 0);
        sb_empty("t2_sb");

        // Count above DEPTH
        do_reset();
        send_byte(8'h2C); send_byte(8'h01);
        chk("t3_err", err, 2'b01);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        sb_empty("t3_sb");
        chk("t3_cpu_reset", cpu_reset, 1);
        chk("t3_done", done, 0);
        chk("t3_err_sticky", err, 2'b01);

        // Three words back to back
        do_reset();
        send_byte(8'h03); send_byte(8'h00);
        send_word(8'd0, 32'h11223344);
        send_word(8'd1, 32'h55667788);
        send_word(8'd2, 32'hDEADBEEF);
        chk("t4_words_left", words_left, 0);
        tick(1);
        chk("t4_done", done, 1);
        chk("t4_err", err, 0);
        sb_empty("t4_sb");

        // Inter-byte timeout with a partial word
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAB); send_byte(8'hCD);
        tick(10);
        chk("t5_err_before_timeout", err, 0);
        tick(10);
        chk("t5_err", err, 2'b10);
        chk("t5_cpu_reset", cpu_reset, 1);
        chk("t5_done", done, 0);
        send_byte(8'hEF); send_byte(8'h01);
        sb_empty("t5_sb");

        // Reset in the middle of a 2-word load
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_word(8'd0, 32'hA5A50001);
        send_byte(8'h99);
        chk("t6_words_left_mid", words_left, 1);
        do_reset();
        chk("t6_words_left_rst", words_left, 0);
        send_byte(8'h01); send_byte(8'h00);
        send_word(8'd0, 32'hCAFEF00D);
        tick(1);
        chk("t6_done", done, 1);
        chk("t6_cpu_reset", cpu_reset, 0);
        sb_empty("t6_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
